// File: rtl/musa_pkg.sv
// Shared MUSA core definitions: address width, reset vector and the
// fetch sequencer state encoding.
package musa_pkg;

  localparam int unsigned MUSA_ADDR_W     = 32;
  localparam logic [31:0] MUSA_RESET_ADDR = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_MEM = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_HALTED   = 3'd4
  } pc_sequencer_state_t;

endpackage

// File: rtl/pc_sequencer.sv
// Fetch-side PC controller: owns the PC, issues req/ready fetches to
// instruction memory, applies EX redirects, hazard stalls and decode halts,
// and drives the IF/ID flush.
module pc_sequencer
  import musa_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = MUSA_ADDR_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(MUSA_RESET_ADDR)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  stall_i,
  input  logic                  halt_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_target_i,
  input  logic                  imem_ready_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic                  fetch_valid_o,
  output logic [ADDR_WIDTH-1:0] fetch_pc_o,
  output logic                  flush_o,
  output logic                  halted_o
);

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  pc_sequencer_state_t   state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  pend_q;
  logic [ADDR_WIDTH-1:0] pend_tgt_q;
  logic                  fetch_valid_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic                  flush_q;
  logic                  halted_q;

  // Request is live in FETCH unless stalled; an outstanding transaction in
  // WAIT_MEM must complete, so stall cannot drop it there.
  assign imem_req_o    = (state_q == ST_WAIT_MEM) ||
                         ((state_q == ST_FETCH) && !stall_i);
  assign imem_addr_o   = pc_q;
  assign fetch_valid_o = fetch_valid_q;
  assign fetch_pc_o    = fetch_pc_q;
  assign flush_o       = flush_q;
  assign halted_o      = halted_q;

  // Sequencer FSM with PC, redirect capture and registered pipeline outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_ADDR;
      pend_q        <= 1'b0;
      pend_tgt_q    <= '0;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= '0;
      flush_q       <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      unique case (state_q)
        ST_BOOT: state_q <= ST_FETCH;

        ST_FETCH: begin
          if (redirect_valid_i) begin
            // Redirect wins even over a same-cycle accept: the fetch is wrong-path.
            pc_q    <= redirect_target_i;
            state_q <= ST_FLUSH;
            flush_q <= 1'b1;
          end else if (halt_i) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end else if (!stall_i) begin
            if (imem_ready_i) begin
              fetch_valid_q <= 1'b1;
              fetch_pc_q    <= pc_q;
              pc_q          <= pc_q + ONE;
            end else begin
              state_q <= ST_WAIT_MEM;
            end
          end
        end

        ST_WAIT_MEM: begin
          if (imem_ready_i) begin
            if (redirect_valid_i || pend_q) begin
              // Completed instruction is wrong-path; newest redirect target wins.
              pc_q    <= redirect_valid_i ? redirect_target_i : pend_tgt_q;
              state_q <= ST_FLUSH;
              flush_q <= 1'b1;
            end else begin
              fetch_valid_q <= 1'b1;
              fetch_pc_q    <= pc_q;
              pc_q          <= pc_q + ONE;
              state_q       <= ST_FETCH;
            end
          end else if (redirect_valid_i) begin
            pend_q     <= 1'b1;
            pend_tgt_q <= redirect_target_i;
          end
        end

        ST_FLUSH: begin
          pend_q <= 1'b0;
          if (redirect_valid_i) begin
            pc_q    <= redirect_target_i;
            flush_q <= 1'b1;
          end else begin
            state_q <= ST_FETCH;
          end
        end

        ST_HALTED: halted_q <= 1'b1;

        default: state_q <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side program-counter controller for the MUSA core. It owns the PC register, issues fetch requests to instruction memory with a req/ready handshake, and applies redirects from the EX-stage next-address unit (taken branch or jump). It also applies stalls from the hazard unit and halts from decode. It sits between the EX next-address logic and the IF/ID pipeline register, and generates the IF/ID flush.

## Interface
- ADDR_WIDTH, 32, PC/address width; PC is word-addressed (sequential step +1)
- RESET_ADDR, 0, PC value after reset
---
- clock  in  1  single core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit: inhibit issuing a new fetch
- halt  in  1  decode: halt instruction seen
- redirect_valid  in  1  EX: branch taken or jump, one-cycle pulse
- redirect_target  in  ADDR_WIDTH  EX: computed next address
- imem_ready  in  1  instruction memory accepts/completes current request
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_WIDTH  fetch address (= PC)
- fetch_valid  out  1  one-cycle pulse: instruction at fetch_pc delivered to IF/ID
- fetch_pc  out  ADDR_WIDTH  address of delivered instruction
- flush  out  1  clear IF/ID (and younger) contents
- halted  out  1  sequencer stopped

## Operation
- States: BOOT, FETCH, WAIT_MEM, FLUSH, HALTED.
- Reset (asynchronous, active-low):
  - state=BOOT, pc=RESET_ADDR, redirect_pending=0.
  - Outputs: fetch_valid=0, fetch_pc=0, flush=0, halted=0, imem_req=0.
- BOOT: imem_req=0; unconditional move to FETCH.
- Priority in FETCH, evaluated in this order:
  1. redirect_valid: pc<=redirect_target; go to FLUSH; no accept counted even if imem_ready=1.
  2. halt: go to HALTED.
  3. stall: hold pc; imem_req=0.
  4. Otherwise imem_req=1.
     - If imem_ready=1 (accept): fetch_valid pulses for pc; pc<=pc+1; stay in FETCH.
     - Else go to WAIT_MEM.
- WAIT_MEM:
  - imem_req=1; imem_addr held stable; stall is ignored because the transaction must finish.
  - redirect_valid with imem_ready=0: latch target into redirect_pending/pending_target.
  - imem_ready=1, no redirect pending and none this cycle: fetch_valid pulses; pc<=pc+1; go to FETCH.
  - imem_ready=1 with a redirect pending or arriving: discard the instruction (no fetch_valid); pc<=target; go to FLUSH. A same-cycle redirect_target overrides the pending one.
  - halt is ignored in WAIT_MEM; decode re-presents it.
- FLUSH: imem_req=0; flush=1 for exactly this one cycle; clear redirect_pending; go to FETCH. A redirect_valid in FLUSH replaces pc and stays in FLUSH for one more cycle.
- HALTED: imem_req=0; halted=1; pc frozen. Exit only through reset; redirect and stall are ignored.
- Arithmetic: pc+1 is modulo 2^ADDR_WIDTH; all-ones wraps to 0 with no flag.

## Timing
- imem_req and imem_addr are combinational from state, pc and stall. Accept = imem_req && imem_ready in the same cycle.
- fetch_valid, fetch_pc, flush and halted are registered.
  - fetch_valid/fetch_pc appear the cycle after accept.
  - flush is high during the FLUSH-state cycle.
- Redirect-to-new-request latency:
  - From FETCH: 2 cycles (redirect edge, FLUSH, request at target).
  - From WAIT_MEM: memory latency + 2.
- Sustained throughput with imem_ready tied high: one fetch per cycle.
- Reset mid-transaction drops the request immediately; the memory must tolerate an abandoned request.

## Structure
- Shared package musa_pkg:
  - State enum for pc_sequencer_state_t.
  - Default RESET_ADDR.
  - The core's address-width constant.
- Single module; no sub-module. The redirect_pending/pending_target capture register is inline.

## Test plan
- Reset release, imem_ready=1, no stall: imem_addr 0,1,2,3 on consecutive cycles; fetch_valid with fetch_pc 0,1,2 one cycle later; halted=0.
- Redirect in FETCH, redirect_target=0x40 while pc=5: flush=1 for one cycle; next request at 0x40; no fetch_valid for address 5.
- imem_ready held low 3 cycles at pc=8, redirect to 0x100 in the 2nd wait cycle: the instruction at 8 is discarded with no fetch_valid; flush pulses; next imem_addr=0x100.
- stall high 4 cycles at pc=12: imem_req=0 and pc stays 12; release stall and the request at 12 resumes.
- halt at pc=20: halted=1 from the next cycle and imem_req stays 0; a later redirect is ignored; reset low returns pc to RESET_ADDR.
- pc=0xFFFFFFFF accepted: the next imem_addr=0x00000000.
